// File: rtl/life_pingpong_engine.sv
// Game-of-Life generation engine with two ping-pong grid banks.
// The display bank feeds the renderer and cursor edits; the other bank collects the next generation.
module life_pingpong_engine #(
    parameter int GRID_W = 80,
    parameter int GRID_H = 60,
    parameter int XW     = 7,
    parameter int YW     = 6,
    parameter int WRAP   = 0,
    parameter int GEN_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             clear_i,
    input  logic             edit_i,
    input  logic [XW-1:0]    edit_x,
    input  logic [YW-1:0]    edit_y,
    input  logic [XW-1:0]    rd_x,
    input  logic [YW-1:0]    rd_y,
    output logic             rd_cell,
    output logic             edit_done_o,
    output logic             busy_o,
    output logic [GEN_W-1:0] gen_count_o
);

    localparam int XW1 = XW + 1;
    localparam int YW1 = YW + 1;
    localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);
    localparam logic [XW:0]   X_LIM  = XW1'(GRID_W);
    localparam logic [YW:0]   Y_LIM  = YW1'(GRID_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_EDIT,
        S_COMPUTE,
        S_SWAP
    } state_t;

    state_t            state, state_nxt;
    logic [YW-1:0]     row;
    logic [XW-1:0]     cx;
    logic [YW-1:0]     cy;
    logic [XW-1:0]     ex;
    logic [YW-1:0]     ey;
    logic              bank_sel;

    logic [GRID_W-1:0] bank0 [GRID_H];
    logic [GRID_W-1:0] bank1 [GRID_H];

    logic              last_cell;
    logic              edit_ok;
    logic              rd_ok;
    logic [XW-1:0]     xm, xp;
    logic [YW-1:0]     ym, yp;
    logic              xm_ok, xp_ok, ym_ok, yp_ok;
    logic [GRID_W-1:0] row_m, row_c, row_p, rd_row;
    logic [3:0]        nbr_cnt;
    logic              cell_nxt;

    // bank_sel names the display bank; the other one is the compute target.
    function automatic logic [GRID_W-1:0] disp_row(input logic [YW-1:0] y);
        return bank_sel ? bank1[y] : bank0[y];
    endfunction

    assign last_cell = (cx == X_LAST) && (cy == Y_LAST);
    assign edit_ok   = ({1'b0, ex} < X_LIM) && ({1'b0, ey} < Y_LIM);
    assign rd_ok     = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
    assign busy_o    = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (clear_i)              state_nxt = S_CLEAR;
                else if (edit_i)          state_nxt = S_EDIT;
                else if (step_i || run_i) state_nxt = S_COMPUTE;
            end
            S_CLEAR:   if (row == Y_LAST) state_nxt = S_IDLE;
            S_EDIT:    state_nxt = S_IDLE;
            S_COMPUTE: begin
                if (clear_i)        state_nxt = S_CLEAR;
                else if (last_cell) state_nxt = S_SWAP;
            end
            S_SWAP: begin
                if (clear_i)    state_nxt = S_CLEAR;
                else if (run_i) state_nxt = S_COMPUTE;
                else            state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Neighbour coordinates; the *_ok flags kill off-grid neighbours when not wrapping.
    always_comb begin
        xm      = (cx == '0)     ? X_LAST : cx - 1'b1;
        xp      = (cx == X_LAST) ? '0     : cx + 1'b1;
        ym      = (cy == '0)     ? Y_LAST : cy - 1'b1;
        yp      = (cy == Y_LAST) ? '0     : cy + 1'b1;
        xm_ok   = (cx != '0)     || (WRAP != 0);
        xp_ok   = (cx != X_LAST) || (WRAP != 0);
        ym_ok   = (cy != '0)     || (WRAP != 0);
        yp_ok   = (cy != Y_LAST) || (WRAP != 0);
        row_m   = ym_ok ? disp_row(ym) : '0;
        row_c   = disp_row(cy);
        row_p   = yp_ok ? disp_row(yp) : '0;
        nbr_cnt = 4'(row_m[xm] & xm_ok) + 4'(row_m[cx]) + 4'(row_m[xp] & xp_ok)
                + 4'(row_c[xm] & xm_ok)                 + 4'(row_c[xp] & xp_ok)
                + 4'(row_p[xm] & xm_ok) + 4'(row_p[cx]) + 4'(row_p[xp] & xp_ok);
        cell_nxt = (nbr_cnt == 4'd3) || (row_c[cx] && (nbr_cnt == 4'd2));
        rd_row  = disp_row(rd_y);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_CLEAR;
            row         <= '0;
            cx          <= '0;
            cy          <= '0;
            ex          <= '0;
            ey          <= '0;
            bank_sel    <= 1'b0;
            rd_cell     <= 1'b0;
            edit_done_o <= 1'b0;
            gen_count_o <= '0;
        end else begin
            state       <= state_nxt;
            edit_done_o <= (state == S_EDIT);
            rd_cell     <= rd_ok & rd_row[rd_x];

            if (state == S_CLEAR) row <= (row == Y_LAST) ? '0 : row + 1'b1;

            if (state == S_IDLE) begin
                ex <= edit_x;
                ey <= edit_y;
            end

            // Restart the raster on every COMPUTE entry so an aborted pass leaves no residue.
            if (state_nxt == S_COMPUTE && state != S_COMPUTE) begin
                cx <= '0;
                cy <= '0;
            end else if (state == S_COMPUTE) begin
                if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end

            if (state == S_CLEAR) begin
                gen_count_o <= '0;
            end else if (state == S_SWAP && !clear_i) begin
                bank_sel    <= ~bank_sel;
                gen_count_o <= gen_count_o + 1'b1;
            end
        end
    end

    // Grid storage carries no reset; CLEAR sweeps both banks row by row.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            bank0[row] <= '0;
            bank1[row] <= '0;
        end else if (state == S_EDIT && edit_ok) begin
            if (bank_sel) bank1[ey][ex] <= ~bank1[ey][ex];
            else          bank0[ey][ex] <= ~bank0[ey][ex];
        end else if (state == S_COMPUTE) begin
            if (bank_sel) bank0[cy][cx] <= cell_nxt;
            else          bank1[cy][cx] <= cell_nxt;
        end
    end

endmodule

// File: tb/tb_life_pingpong_engine.sv
// Scoreboard bench: a flat-edge and a toroidal engine share stimulus and are checked against
// a cell-array Life model; a monitor pops expected reads, edit pulses and busy/generation results.
module tb_life_pingpong_engine;

    localparam int TW    = 12;
    localparam int TH    = 9;
    localparam int TXW   = 4;
    localparam int TYW   = 4;
    localparam int TGW   = 4;
    localparam int NCELL = TW * TH;
    localparam int GMOD  = 1 << TGW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run_i = 1'b0, step_i = 1'b0, clear_i = 1'b0, edit_i = 1'b0;
    logic [TXW-1:0] edit_x = '0, rd_x = '0;
    logic [TYW-1:0] edit_y = '0, rd_y = '0;
    logic           rd_cell [2];
    logic           edit_done [2];
    logic           busy [2];
    logic [TGW-1:0] gen_cnt [2];

    life_pingpong_engine #(.GRID_W(TW), .GRID_H(TH), .XW(TXW), .YW(TYW), .WRAP(0), .GEN_W(TGW)) u_flat (
        .clk(clk), .rst_n(rst_n), .run_i(run_i), .step_i(step_i), .clear_i(clear_i),
        .edit_i(edit_i), .edit_x(edit_x), .edit_y(edit_y), .rd_x(rd_x), .rd_y(rd_y),
        .rd_cell(rd_cell[0]), .edit_done_o(edit_done[0]), .busy_o(busy[0]), .gen_count_o(gen_cnt[0]));

    life_pingpong_engine #(.GRID_W(TW), .GRID_H(TH), .XW(TXW), .YW(TYW), .WRAP(1), .GEN_W(TGW)) u_torus (
        .clk(clk), .rst_n(rst_n), .run_i(run_i), .step_i(step_i), .clear_i(clear_i),
        .edit_i(edit_i), .edit_x(edit_x), .edit_y(edit_y), .rd_x(rd_x), .rd_y(rd_y),
        .rd_cell(rd_cell[1]), .edit_done_o(edit_done[1]), .busy_o(busy[1]), .gen_count_o(gen_cnt[1]));

    always #5 clk = ~clk;

    typedef struct { int gen; int cycles; } gexp_t;
    gexp_t      gq0[$], gq1[$];
    logic [1:0] rd_q[$];
    int         ed_pend [2] = '{0, 0};
    int         bcnt [2]    = '{0, 0};
    logic       rd_req = 1'b0, rd_pend = 1'b0;
    int         n_chk = 0, n_err = 0;
    bit         mg [2][TH][TW];
    int         mgen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain neighbour counting over the cell array, per edge mode.
    function automatic void model_step();
        bit nx [2][TH][TW];
        for (int w = 0; w < 2; w++)
            for (int y = 0; y < TH; y++)
                for (int x = 0; x < TW; x++) begin
                    int c;
                    c = 0;
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++) begin
                            int yy, xx;
                            yy = y + dy;
                            xx = x + dx;
                            if (w == 1) begin
                                yy = (yy + TH) % TH;
                                xx = (xx + TW) % TW;
                            end
                            if ((dx != 0 || dy != 0) && yy >= 0 && yy < TH && xx >= 0 && xx < TW)
                                c += int'(mg[w][yy][xx]);
                        end
                    nx[w][y][x] = (c == 3) || (mg[w][y][x] && c == 2);
                end
        mg = nx;
    endfunction

    function automatic void model_clear();
        for (int w = 0; w < 2; w++)
            for (int y = 0; y < TH; y++)
                for (int x = 0; x < TW; x++) mg[w][y][x] = 1'b0;
        mgen = 0;
    endfunction

    // Monitor: reset values while held, edit pulses, busy episodes, and read data.
    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                check($sformatf("reset rd_cell[%0d]", d), int'(rd_cell[d]), 0);
                check($sformatf("reset edit_done[%0d]", d), int'(edit_done[d]), 0);
                check($sformatf("reset busy[%0d]", d), int'(busy[d]), 1);
                check($sformatf("reset gen_count[%0d]", d), int'(gen_cnt[d]), 0);
                bcnt[d] = 0;
            end else begin
                if (edit_done[d]) begin
                    check($sformatf("edit_done expected[%0d]", d), int'(ed_pend[d] > 0), 1);
                    if (ed_pend[d] > 0) ed_pend[d]--;
                end
                if (busy[d]) begin
                    bcnt[d]++;
                end else if (bcnt[d] > 0) begin
                    gexp_t e;
                    int    have;
                    have = (d == 0) ? gq0.size() : gq1.size();
                    check($sformatf("busy episode expected[%0d]", d), int'(have > 0), 1);
                    if (have > 0) begin
                        if (d == 0) e = gq0.pop_front();
                        else        e = gq1.pop_front();
                        check($sformatf("gen_count[%0d]", d), int'(gen_cnt[d]), e.gen);
                        check($sformatf("busy cycles[%0d]", d), bcnt[d], e.cycles);
                    end
                    bcnt[d] = 0;
                end
            end
        end
        if (rst_n && rd_pend) begin
            logic [1:0] e;
            check("read expected", int'(rd_q.size() > 0), 1);
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                check("rd_cell flat", int'(rd_cell[0]), int'(e[0]));
                check("rd_cell torus", int'(rd_cell[1]), int'(e[1]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gen(input int g, input int c);
        gexp_t e;
        e.gen    = g;
        e.cycles = c;
        gq0.push_back(e);
        gq1.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        tick();
        while ((busy[0] || busy[1]) && n < budget) begin
            tick();
            n++;
        end
        check("idle within budget", int'(n < budget), 1);
        tick();
    endtask

    task automatic do_edit(input int x, input int y);
        edit_x = TXW'(x);
        edit_y = TYW'(y);
        edit_i = 1'b1;
        ed_pend[0]++;
        ed_pend[1]++;
        push_gen(mgen, 1);
        tick();
        edit_i = 1'b0;
        if (x < TW && y < TH) begin
            mg[0][y][x] = ~mg[0][y][x];
            mg[1][y][x] = ~mg[1][y][x];
        end
        wait_idle(10);
    endtask

    task automatic do_step();
        step_i = 1'b1;
        push_gen((mgen + 1) % GMOD, NCELL + 1);
        tick();
        step_i = 1'b0;
        model_step();
        mgen = (mgen + 1) % GMOD;
        wait_idle(NCELL + 20);
    endtask

    task automatic do_run(input int n);
        run_i = 1'b1;
        push_gen((mgen + n) % GMOD, n * (NCELL + 1));
        tick();
        repeat (n * (NCELL + 1) - 1) tick();
        run_i = 1'b0;
        repeat (n) model_step();
        mgen = (mgen + n) % GMOD;
        wait_idle(40);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        push_gen(0, TH);
        tick();
        clear_i = 1'b0;
        model_clear();
        wait_idle(TH + 10);
    endtask

    task automatic read_at(input int x, input int y);
        rd_x   = TXW'(x);
        rd_y   = TYW'(y);
        rd_req = 1'b1;
        if (x < TW && y < TH) rd_q.push_back({mg[1][y][x], mg[0][y][x]});
        else                  rd_q.push_back(2'b00);
        tick();
    endtask

    task automatic readback();
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++) read_at(x, y);
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        model_clear();
        push_gen(0, TH);
        repeat (3) tick();
        rst_n = 1'b1;
        wait_idle(TH + 10);
        readback();

        // Blinker turns horizontal after one step.
        do_edit(5, 3); do_edit(5, 4); do_edit(5, 5);
        do_step();
        readback();

        // Block at the origin and a lone far-corner cell (touches the block only when wrapping).
        do_clear();
        do_edit(0, 0); do_edit(1, 0); do_edit(0, 1); do_edit(1, 1);
        do_edit(TW - 1, TH - 1);
        do_step();
        readback();

        // Off-grid edits pulse without writing; off-grid reads return 0.
        do_edit(13, 2);
        do_edit(3, 11);
        read_at(14, 1);
        read_at(2, 12);
        rd_req = 1'b0;
        tick();
        tick();

        // Edit arriving mid-generation is dropped.
        step_i = 1'b1;
        push_gen((mgen + 1) % GMOD, NCELL + 1);
        tick();
        step_i = 1'b0;
        repeat (10) tick();
        edit_x = TXW'(6);
        edit_y = TYW'(6);
        edit_i = 1'b1;
        tick();
        edit_i = 1'b0;
        model_step();
        mgen = (mgen + 1) % GMOD;
        wait_idle(NCELL + 20);
        readback();

        // Same-cycle requests: clear beats edit, edit beats step.
        clear_i = 1'b1;
        edit_i  = 1'b1;
        push_gen(0, TH);
        tick();
        clear_i = 1'b0;
        edit_i  = 1'b0;
        model_clear();
        wait_idle(TH + 10);
        edit_x = TXW'(4);
        edit_y = TYW'(2);
        edit_i = 1'b1;
        step_i = 1'b1;
        ed_pend[0]++;
        ed_pend[1]++;
        push_gen(mgen, 1);
        tick();
        edit_i = 1'b0;
        step_i = 1'b0;
        mg[0][2][4] = 1'b1;
        mg[1][2][4] = 1'b1;
        wait_idle(10);
        readback();

        // Random soups run for a few generations.
        for (int r = 0; r < 3; r++) begin
            do_clear();
            repeat (15) do_edit($urandom_range(TW - 1), $urandom_range(TH - 1));
            do_run($urandom_range(4, 1));
            readback();
        end

        // Glider on the torus through a generation-counter wrap.
        do_clear();
        do_edit(1, 0); do_edit(2, 1); do_edit(0, 2); do_edit(1, 2); do_edit(2, 2);
        do_run(18);
        readback();

        // Clear aborts a generation part way through.
        k = $urandom_range(NCELL - 5, 5);
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        repeat (k - 1) tick();
        clear_i = 1'b1;
        push_gen(0, k + TH);
        tick();
        clear_i = 1'b0;
        model_clear();
        wait_idle(NCELL + TH + 20);
        readback();

        // Reset mid-generation after building some state.
        do_edit(3, 3); do_edit(4, 3); do_edit(5, 3);
        do_step();
        read_at(4, 3);
        rd_req = 1'b0;
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        push_gen(0, TH);
        model_clear();
        rst_n = 1'b1;
        wait_idle(TH + 10);
        readback();

        check("read queue drained", rd_q.size(), 0);
        check("flat episodes drained", gq0.size(), 0);
        check("torus episodes drained", gq1.size(), 0);
        check("flat edit pulses drained", ed_pend[0], 0);
        check("torus edit pulses drained", ed_pend[1], 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
